hit_resolver: RTL and testbench
===============================

// Module: hit_resolver
// PURPOSE
//  Frame-rate combat arbiter between Player1 and Player2. Consumes each player's FSM state,
//  basic hithurtbox and main hurtbox. Once per frame tick it detects attack connections,
//  applies damage and hitstun, and declares the round winner. Its outputs drive the
//  player stun inputs and the health bar and HEX overlays in the top-level renderer.
// PARAMETERS
//  MAX_HEALTH  8'd100  health loaded at reset and on restart
//  HIT_DMG     8'd10   damage per unblocked hit
//  BLOCK_DMG   8'd2    chip damage when the defender is in MOVE_BACKWARD (state 2)
//  HITSTUN     6'd20   frames of stun after an unblocked hit
//  BLOCKSTUN   6'd8    frames of stun after a blocked hit
// PORTS
//  clk            in   1   system clock
//  rst            in   1   synchronous reset, active-high
//  frame_tick     in   1   one-cycle strobe per frame (pixel 639,479)
//  restart        in   1   pulse; starts a new round from GAME_OVER
//  p1_state       in   4   Player1 FSM state (0 idle,1 fwd,2 back,3 atk_start,4 atk_end,5 atk_pull)
//  p2_state       in   4   Player2 FSM state, same encoding
//  p1_hit_{x1,x2,y1,y2}   in 10 each  P1 basic hithurtbox, inclusive corners
//  p1_hurt_{x1,x2,y1,y2}  in 10 each  P1 main hurtbox, inclusive corners
//  p2_hit_{x1,x2,y1,y2}   in 10 each  P2 basic hithurtbox
//  p2_hurt_{x1,x2,y1,y2}  in 10 each  P2 main hurtbox
//  p1_health      out  8   P1 remaining health
//  p2_health      out  8   P2 remaining health
//  p1_got_hit     out  1   one-cycle pulse: P1 was struck this frame
//  p2_got_hit     out  1   one-cycle pulse: P2 was struck this frame
//  p1_stunned     out  1   high while P1 stun counter != 0
//  p2_stunned     out  1   high while P2 stun counter != 0
//  game_over      out  1   high in GAME_OVER state
//  winner         out  2   00 none, 01 P1, 10 P2, 11 draw; valid while game_over
// BEHAVIOUR
//  Reset: health=MAX_HEALTH for both players; pulses, stun counters, hit latches,
//   game_over and winner=0; FSM=FIGHT.
//  Overlap test: boxes A and B overlap iff A.x1<=B.x2 && B.x1<=A.x2 && A.y1<=B.y2 && B.y1<=A.y2.
//   Unsigned 10-bit; coordinates are inclusive.
//  Attack active: hitbox is live only while the attacker's state==4 (ATTACK_END).
//  Evaluation: only in a cycle with frame_tick=1. Results register on that edge.
//   Outputs change 1 cycle after frame_tick. Outside ticks all state holds; pulses are 0.
//  Connect (P1 on P2): P1 active && overlap(p1_hit,p2_hurt) && !p1_latch.
//   On connect set p1_latch. p1_latch clears on the first tick where p1_state!=4,
//   so each attack hits at most once. P2 on P1 is symmetric.
//  Damage: defender state==2 -> BLOCK_DMG and BLOCKSTUN; otherwise HIT_DMG and HITSTUN.
//   Health saturates at 0; there is no underflow.
//  Stun: counter reloads on connect, even if already nonzero. Otherwise it decrements by 1
//   per tick and floors at 0. stunned = (counter!=0).
//  Simultaneous connects on the same tick: both apply, producing a trade.
//  FSM FIGHT -> GAME_OVER on the tick after which either health==0.
//   winner: P2 health 0 only -> 01; P1 health 0 only -> 10; both 0 -> 11.
//  GAME_OVER: no evaluation; health and winner are frozen; stun counters still run down.
//  restart: honoured only in GAME_OVER, on any cycle. Next cycle: health=MAX_HEALTH,
//   latches clear, winner=0, FSM=FIGHT. restart in FIGHT is ignored.
//  rst mid-round overrides everything, including restart and a coincident frame_tick.
// STRUCTURE
//  demoman_pkg: player state codes (ST_IDLE..ST_ATK_PULL), FSM encoding (FIGHT, GAME_OVER),
//   winner codes, HEALTH_W=8, STUN_W=6. player.v shares this package.
//  Sub-module box_overlap (purely combinational, 8x10-bit in, 1 out), instantiated twice:
//   P1hit vs P2hurt and P2hit vs P1hurt.
//  Per-player damage/stun/latch logic is written as one generate-free block per player.
// TESTING
//  1 Reset, P1 state=4, boxes overlap, one tick -> next cycle p2_health=90, p2_got_hit=1 (1 cycle), p2_stunned=1.
//  2 P1 held in state 4 overlapping for 5 ticks -> p2_health=90 only. P1 to 0 then back to 4 -> 80.
//  3 P2 state=2 when struck -> p2_health=98; stun clears after exactly 8 ticks.
//  4 Both in state 4 with mutual overlap on the same tick -> both health 90, both got_hit pulse.
//  5 Edge-touch boxes (p1_hit_x2==p2_hurt_x1) -> hit; gap of 1 -> no hit; no overlap while state!=4.
//  6 Drive P2 health 10->0 -> game_over=1, winner=01, hits ignored; restart -> health 100/100, winner=00.

Source files
------------

// File: rtl/demoman_pkg.sv
// demoman_pkg: shared player state codes, arbiter FSM encoding, winner codes and widths
package demoman_pkg;
  localparam int HEALTH_W = 8;
  localparam int STUN_W = 6;
  localparam int COORD_W = 10;
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FWD       = 4'd1,
    ST_BACK      = 4'd2,
    ST_ATK_START = 4'd3,
    ST_ATK_END   = 4'd4,
    ST_ATK_PULL  = 4'd5
  } player_state_t;
  typedef enum logic {FIGHT = 1'b0, GAME_OVER = 1'b1} fsm_t;
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;
  function automatic logic [HEALTH_W-1:0] sat_sub(input logic [HEALTH_W-1:0] a, input logic [HEALTH_W-1:0] b);
    return (a > b) ? a - b : '0;
  endfunction
endpackage

// File: rtl/box_overlap.sv
// box_overlap: inclusive-corner axis-aligned rectangle intersection test
module box_overlap import demoman_pkg::*; (
  input  logic [COORD_W-1:0] i_ax1,
  input  logic [COORD_W-1:0] i_ax2,
  input  logic [COORD_W-1:0] i_ay1,
  input  logic [COORD_W-1:0] i_ay2,
  input  logic [COORD_W-1:0] i_bx1,
  input  logic [COORD_W-1:0] i_bx2,
  input  logic [COORD_W-1:0] i_by1,
  input  logic [COORD_W-1:0] i_by2,
  output logic               o_hit
);
  assign o_hit = (i_ax1 <= i_bx2) && (i_bx1 <= i_ax2) && (i_ay1 <= i_by2) && (i_by1 <= i_ay2);
endmodule

// File: rtl/hit_resolver.sv
// hit_resolver: per-frame P1/P2 hit detection, damage, stun and round-winner arbiter
module hit_resolver import demoman_pkg::*; #(
  parameter logic [HEALTH_W-1:0] MAX_HEALTH = 8'd100,
  parameter logic [HEALTH_W-1:0] HIT_DMG    = 8'd10,
  parameter logic [HEALTH_W-1:0] BLOCK_DMG  = 8'd2,
  parameter logic [STUN_W-1:0]   HITSTUN    = 6'd20,
  parameter logic [STUN_W-1:0]   BLOCKSTUN  = 6'd8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic                restart,
  input  logic [3:0]          p1_state,
  input  logic [3:0]          p2_state,
  input  logic [COORD_W-1:0]  p1_hit_x1,
  input  logic [COORD_W-1:0]  p1_hit_x2,
  input  logic [COORD_W-1:0]  p1_hit_y1,
  input  logic [COORD_W-1:0]  p1_hit_y2,
  input  logic [COORD_W-1:0]  p1_hurt_x1,
  input  logic [COORD_W-1:0]  p1_hurt_x2,
  input  logic [COORD_W-1:0]  p1_hurt_y1,
  input  logic [COORD_W-1:0]  p1_hurt_y2,
  input  logic [COORD_W-1:0]  p2_hit_x1,
  input  logic [COORD_W-1:0]  p2_hit_x2,
  input  logic [COORD_W-1:0]  p2_hit_y1,
  input  logic [COORD_W-1:0]  p2_hit_y2,
  input  logic [COORD_W-1:0]  p2_hurt_x1,
  input  logic [COORD_W-1:0]  p2_hurt_x2,
  input  logic [COORD_W-1:0]  p2_hurt_y1,
  input  logic [COORD_W-1:0]  p2_hurt_y2,
  output logic [HEALTH_W-1:0] p1_health,
  output logic [HEALTH_W-1:0] p2_health,
  output logic                p1_got_hit,
  output logic                p2_got_hit,
  output logic                p1_stunned,
  output logic                p2_stunned,
  output logic                game_over,
  output logic [1:0]          winner
);
  fsm_t                r_state;
  logic [HEALTH_W-1:0] r_p1_health, r_p2_health;
  logic [STUN_W-1:0]   r_p1_stun, r_p2_stun;
  logic                r_p1_latch, r_p2_latch;
  logic                r_p1_got_hit, r_p2_got_hit;
  logic [1:0]          r_winner;
  logic                w_ov_p1_on_p2, w_ov_p2_on_p1;
  logic                w_run, w_p1_conn, w_p2_conn;
  logic [HEALTH_W-1:0] w_p1_health_nx, w_p2_health_nx;
  logic [STUN_W-1:0]   w_p1_stun_nx, w_p2_stun_nx;
  logic                w_p1_latch_nx, w_p2_latch_nx;
  box_overlap u_p1_on_p2 (
    .i_ax1(p1_hit_x1), .i_ax2(p1_hit_x2), .i_ay1(p1_hit_y1), .i_ay2(p1_hit_y2),
    .i_bx1(p2_hurt_x1), .i_bx2(p2_hurt_x2), .i_by1(p2_hurt_y1), .i_by2(p2_hurt_y2),
    .o_hit(w_ov_p1_on_p2)
  );
  box_overlap u_p2_on_p1 (
    .i_ax1(p2_hit_x1), .i_ax2(p2_hit_x2), .i_ay1(p2_hit_y1), .i_ay2(p2_hit_y2),
    .i_bx1(p1_hurt_x1), .i_bx2(p1_hurt_x2), .i_by1(p1_hurt_y1), .i_by2(p1_hurt_y2),
    .o_hit(w_ov_p2_on_p1)
  );
  assign w_run = frame_tick && (r_state == FIGHT);
  assign w_p1_conn = w_run && (p1_state == ST_ATK_END) && w_ov_p1_on_p2 && !r_p1_latch;
  assign w_p2_conn = w_run && (p2_state == ST_ATK_END) && w_ov_p2_on_p1 && !r_p2_latch;
  // P2 takes P1's attack: a defender walking backward blocks for chip damage and short stun
  always_comb begin
    w_p2_health_nx = w_p1_conn ? sat_sub(r_p2_health, (p2_state == ST_BACK) ? BLOCK_DMG : HIT_DMG) : r_p2_health;
    w_p2_stun_nx = w_p1_conn ? ((p2_state == ST_BACK) ? BLOCKSTUN : HITSTUN)
                 : (frame_tick && r_p2_stun != '0) ? r_p2_stun - 1'b1 : r_p2_stun;
    w_p1_latch_nx = w_run ? ((p1_state != ST_ATK_END) ? 1'b0 : (r_p1_latch | w_p1_conn)) : r_p1_latch;
  end
  // P1 takes P2's attack
  always_comb begin
    w_p1_health_nx = w_p2_conn ? sat_sub(r_p1_health, (p1_state == ST_BACK) ? BLOCK_DMG : HIT_DMG) : r_p1_health;
    w_p1_stun_nx = w_p2_conn ? ((p1_state == ST_BACK) ? BLOCKSTUN : HITSTUN)
                 : (frame_tick && r_p1_stun != '0) ? r_p1_stun - 1'b1 : r_p1_stun;
    w_p2_latch_nx = w_run ? ((p2_state != ST_ATK_END) ? 1'b0 : (r_p2_latch | w_p2_conn)) : r_p2_latch;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FIGHT;
      r_p1_health  <= MAX_HEALTH;
      r_p2_health  <= MAX_HEALTH;
      r_p1_stun    <= '0;
      r_p2_stun    <= '0;
      r_p1_latch   <= 1'b0;
      r_p2_latch   <= 1'b0;
      r_p1_got_hit <= 1'b0;
      r_p2_got_hit <= 1'b0;
      r_winner     <= WIN_NONE;
    end else begin
      r_p1_stun    <= w_p1_stun_nx;
      r_p2_stun    <= w_p2_stun_nx;
      r_p1_got_hit <= w_p2_conn;
      r_p2_got_hit <= w_p1_conn;
      case (r_state)
        FIGHT: begin
          r_p1_health <= w_p1_health_nx;
          r_p2_health <= w_p2_health_nx;
          r_p1_latch  <= w_p1_latch_nx;
          r_p2_latch  <= w_p2_latch_nx;
          if (w_run && (w_p1_health_nx == '0 || w_p2_health_nx == '0)) begin
            r_state  <= GAME_OVER;
            r_winner <= {w_p1_health_nx == '0, w_p2_health_nx == '0};
          end
        end
        GAME_OVER: if (restart) begin
          r_state     <= FIGHT;
          r_p1_health <= MAX_HEALTH;
          r_p2_health <= MAX_HEALTH;
          r_p1_latch  <= 1'b0;
          r_p2_latch  <= 1'b0;
          r_winner    <= WIN_NONE;
        end
        default: r_state <= FIGHT;
      endcase
    end
  end
  assign p1_health  = r_p1_health;
  assign p2_health  = r_p2_health;
  assign p1_got_hit = r_p1_got_hit;
  assign p2_got_hit = r_p2_got_hit;
  assign p1_stunned = (r_p1_stun != '0);
  assign p2_stunned = (r_p2_stun != '0);
  assign game_over  = (r_state == GAME_OVER);
  assign winner     = r_winner;
endmodule

// File: tb/tb_hit_resolver.sv
// tb_hit_resolver: directed-vector self-checking bench for hit_resolver
module tb_hit_resolver;
  logic clk = 1'b0;
  logic rst, frame_tick, restart;
  logic [3:0] p1_state, p2_state;
  logic [9:0] p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2;
  logic [9:0] p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2;
  logic [9:0] p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2;
  logic [9:0] p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2;
  logic [7:0] p1_health, p2_health;
  logic p1_got_hit, p2_got_hit, p1_stunned, p2_stunned, game_over;
  logic [1:0] winner;
  int n_vec = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  hit_resolver dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .restart(restart),
    .p1_state(p1_state), .p2_state(p2_state),
    .p1_hit_x1(p1_hit_x1), .p1_hit_x2(p1_hit_x2), .p1_hit_y1(p1_hit_y1), .p1_hit_y2(p1_hit_y2),
    .p1_hurt_x1(p1_hurt_x1), .p1_hurt_x2(p1_hurt_x2), .p1_hurt_y1(p1_hurt_y1), .p1_hurt_y2(p1_hurt_y2),
    .p2_hit_x1(p2_hit_x1), .p2_hit_x2(p2_hit_x2), .p2_hit_y1(p2_hit_y1), .p2_hit_y2(p2_hit_y2),
    .p2_hurt_x1(p2_hurt_x1), .p2_hurt_x2(p2_hurt_x2), .p2_hurt_y1(p2_hurt_y1), .p2_hurt_y2(p2_hurt_y2),
    .p1_health(p1_health), .p2_health(p2_health),
    .p1_got_hit(p1_got_hit), .p2_got_hit(p2_got_hit),
    .p1_stunned(p1_stunned), .p2_stunned(p2_stunned),
    .game_over(game_over), .winner(winner)
  );
  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask
  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask
  task automatic p1_strike();
    p1_state = 4'd4;
    tick();
    p1_state = 4'd0;
    tick();
  endtask
  initial begin
    rst = 1'b1; frame_tick = 1'b0; restart = 1'b0; p1_state = 4'd0; p2_state = 4'd0;
    p1_hit_x1 = 100; p1_hit_x2 = 120; p1_hit_y1 = 100; p1_hit_y2 = 120;
    p1_hurt_x1 = 80; p1_hurt_x2 = 99; p1_hurt_y1 = 90; p1_hurt_y2 = 130;
    p2_hit_x1 = 300; p2_hit_x2 = 310; p2_hit_y1 = 100; p2_hit_y2 = 120;
    p2_hurt_x1 = 110; p2_hurt_x2 = 150; p2_hurt_y1 = 90; p2_hurt_y2 = 130;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_p1_health", p1_health, 100);
    chk("rst_p2_health", p2_health, 100);
    chk("rst_game_over", game_over, 0);
    chk("rst_winner", winner, 0);
    chk("rst_p2_stunned", p2_stunned, 0);
    chk("rst_p2_got_hit", p2_got_hit, 0);
    p1_state = 4'd4;
    @(negedge clk);
    chk("no_tick_no_hit", p2_health, 100);
    tick();
    chk("t1_p2_health", p2_health, 90);
    chk("t1_p2_got_hit", p2_got_hit, 1);
    chk("t1_p2_stunned", p2_stunned, 1);
    chk("t1_p1_health", p1_health, 100);
    @(negedge clk);
    chk("t1_pulse_one_cycle", p2_got_hit, 0);
    ticks(4);
    chk("t2_held_once", p2_health, 90);
    p1_state = 4'd0;
    tick();
    p1_state = 4'd4;
    tick();
    chk("t2_rehit", p2_health, 80);
    p1_state = 4'd0;
    tick();
    p2_state = 4'd2;
    p1_state = 4'd4;
    tick();
    chk("t3_block_health", p2_health, 78);
    chk("t3_block_stunned", p2_stunned, 1);
    ticks(7);
    chk("t3_stun_7", p2_stunned, 1);
    tick();
    chk("t3_stun_8", p2_stunned, 0);
    chk("t3_health_held", p2_health, 78);
    p1_state = 4'd0; p2_state = 4'd0;
    tick();
    p2_hit_x1 = 90; p2_hit_x2 = 105;
    p1_state = 4'd4; p2_state = 4'd4;
    tick();
    chk("t4_p1_health", p1_health, 90);
    chk("t4_p2_health", p2_health, 68);
    chk("t4_p1_got_hit", p1_got_hit, 1);
    chk("t4_p2_got_hit", p2_got_hit, 1);
    p1_state = 4'd0; p2_state = 4'd0;
    tick();
    p2_hit_x1 = 300; p2_hit_x2 = 310;
    p2_hurt_x1 = 120;
    p1_strike();
    chk("t5_edge_touch", p2_health, 58);
    p2_hurt_x1 = 121;
    p1_state = 4'd4;
    tick();
    chk("t5_gap_health", p2_health, 58);
    chk("t5_gap_got_hit", p2_got_hit, 0);
    p1_state = 4'd0;
    tick();
    p2_hurt_x1 = 110;
    p1_state = 4'd3;
    tick();
    chk("t5_state3_no_hit", p2_health, 58);
    p1_state = 4'd0;
    @(negedge clk) restart = 1'b1;
    @(negedge clk) restart = 1'b0;
    chk("restart_in_fight", p2_health, 58);
    for (int k = 0; k < 5; k++) p1_strike();
    chk("t6_health_8", p2_health, 8);
    chk("t6_not_over", game_over, 0);
    p1_state = 4'd4;
    tick();
    chk("t6_saturate", p2_health, 0);
    chk("t6_game_over", game_over, 1);
    chk("t6_winner", winner, 1);
    chk("t6_p1_health", p1_health, 90);
    p1_state = 4'd0;
    p2_hit_x1 = 90; p2_hit_x2 = 105; p2_state = 4'd4;
    tick();
    chk("t6_ignored_health", p1_health, 90);
    chk("t6_ignored_got_hit", p1_got_hit, 0);
    chk("t6_frozen_winner", winner, 1);
    @(negedge clk) restart = 1'b1;
    @(negedge clk) restart = 1'b0;
    chk("restart_p1_health", p1_health, 100);
    chk("restart_p2_health", p2_health, 100);
    chk("restart_winner", winner, 0);
    chk("restart_game_over", game_over, 0);
    tick();
    chk("restart_latch_clear", p1_health, 90);
    @(negedge clk) begin rst = 1'b1; frame_tick = 1'b1; end
    @(negedge clk) begin rst = 1'b0; frame_tick = 1'b0; end
    chk("midrst_p1_health", p1_health, 100);
    chk("midrst_p1_got_hit", p1_got_hit, 0);
    chk("midrst_p1_stunned", p1_stunned, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
